// File: rtl/oka_seq_mult.sv
// oka_seq_mult -- multi-cycle odd-even Karatsuba carry-less multiplier over GF(2)[x].
//
// Each operand is split into its even- and odd-indexed coefficients:
// A(x) = Ae(x^2) + x*Ao(x^2). The block then reuses a single HALF x HALF
// carry-less core over three cycles:
//   MUL_E computes Pe = Ae*Be, MUL_O computes Po = Ao*Bo, and MUL_M computes
//   Pm = (Ae^Ao)*(Be^Bo).
// In the MUL_M cycle it recombines
//   A*B = Pe(x^2) + x^2*Po(x^2) + x*(Pm^Pe^Po)(x^2)
// into the unreduced product. Handshakes on both sides are valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (discards any in-flight product)
//   in_valid   operands a/b valid
//   in_ready   block accepts operands this cycle (IDLE, or DONE with out_ready)
//   a, b       N-bit operands, bit i = coefficient of x^i
//   out_valid  y holds a valid product
//   out_ready  consumer accepts y this cycle
//   y          (2N-1)-bit unreduced product
//   busy       high in any state other than IDLE
module oka_seq_mult #(
  parameter int N = 82,
  localparam int HALF = N / 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy
);

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("oka_seq_mult: N must be even and >= 4");
  end

  typedef enum logic [2:0] {IDLE, MUL_E, MUL_O, MUL_M, DONE} state_t;

  state_t            state_reg, state_next;
  logic [N-1:0]      a_reg, b_reg;
  logic [N-2:0]      pe_reg, po_reg;
  logic [2*N-2:0]    y_reg, y_next;
  logic              out_valid_reg;
  logic              load;

  // Even/odd operand halves, taken from the captured operands only.
  logic [HALF-1:0]   ae, ao, be, bo, am, bm;

  for (genvar gi = 0; gi < HALF; gi++) begin : g_split
    assign ae[gi] = a_reg[2*gi];
    assign ao[gi] = a_reg[2*gi+1];
    assign be[gi] = b_reg[2*gi];
    assign bo[gi] = b_reg[2*gi+1];
  end

  assign am = ae ^ ao;
  assign bm = be ^ bo;

  function automatic logic [N-2:0] clmul_half(input logic [HALF-1:0] x,
                                              input logic [HALF-1:0] z);
    logic [N-2:0] acc;
    acc = '0;
    for (int i = 0; i < HALF; i++) begin
      if (z[i]) acc = acc ^ ({{(HALF-1){1'b0}}, x} << i);
    end
    return acc;
  endfunction

  // A single shared core, whose operands are selected by the current state.
  logic [HALF-1:0] core_x, core_z;
  logic [N-2:0]    core_p;
  logic [N-2:0]    t_mix;

  always_comb begin
    core_x = ae;
    core_z = be;
    case (state_reg)
      MUL_O: begin
        core_x = ao;
        core_z = bo;
      end
      MUL_M: begin
        core_x = am;
        core_z = bm;
      end
      default: ;
    endcase
    core_p = clmul_half(core_x, core_z);
  end

  // In MUL_M, core_p is Pm. Pe and Po are already registered.
  assign t_mix = core_p ^ pe_reg ^ po_reg;

  // Even product bits combine Pe[i] with Po[i-1]. The two end bits each
  // have only one contributor.
  for (genvar gi = 0; gi < N; gi++) begin : g_even
    if (gi == 0) begin : g_lo
      assign y_next[0] = pe_reg[0];
    end else if (gi == N-1) begin : g_hi
      assign y_next[2*gi] = po_reg[gi-1];
    end else begin : g_mid
      assign y_next[2*gi] = pe_reg[gi] ^ po_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < N-1; gi++) begin : g_odd
    assign y_next[2*gi+1] = t_mix[gi];
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = MUL_E;
        end
      end
      MUL_E: state_next = MUL_O;
      MUL_O: state_next = MUL_M;
      MUL_M: state_next = DONE;
      DONE: begin
        // Delivering a result and accepting the next operands share one
        // edge. This is what gives one result every four cycles.
        in_ready = out_ready;
        if (out_ready) begin
          load       = in_valid;
          state_next = in_valid ? MUL_E : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      pe_reg        <= '0;
      po_reg        <= '0;
      y_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_reg <= a;
        b_reg <= b;
      end
      if (state_reg == MUL_E) pe_reg <= core_p;
      if (state_reg == MUL_O) po_reg <= core_p;
      if (state_reg == MUL_M) begin
        y_reg         <= y_next;
        out_valid_reg <= 1'b1;
      end else if (state_reg == DONE && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign y         = y_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/oka_seq_mult.md
Name: oka_seq_mult

Overview:
- Parametrised, multi-cycle odd-even Karatsuba (OKA) carry-less multiplier over GF(2)[x].
- Successor to the fixed-width combinational OKA stages. It splits each operand into even and odd coefficient halves and time-shares one combinational N/2-bit carry-less core across three cycles. The core computes Pe, Po and Pm.
- Sits in front of the field-reduction stage and uses a valid/ready handshake on both sides, so it fits into area-constrained datapaths.

Parameters:
- N, 82, operand width in bits. Must be even and >= 4; elaboration fails otherwise.
- HALF, N/2, derived; width of the half operands. Not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  operand A, bit i = coefficient of x^i.
- b  input  N  operand B.
- out_valid  output  1  y holds a valid product.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  2N-1  product A(x)*B(x), unreduced.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE; out_valid=0; y=0; busy=0.
  - Internal Pe/Po/operand registers cleared.
  - Overrides every other condition, including mid-operation; the in-flight product is discarded, with no partial output.
- Operand split:
  - Ae[i]=a[2i], Ao[i]=a[2i+1], i=0..HALF-1; same for b.
  - Am=Ae^Ao, Bm=Be^Bo.
- Core: purely combinational HALF x HALF carry-less multiply with an (N-1)-bit result. There is exactly one instance, and it is multiplexed by state.
- FSM states: IDLE, MUL_E, MUL_O, MUL_M, DONE.
  - IDLE: in_ready=1. On in_valid, register a,b and go to MUL_E.
  - MUL_E: Pe <= core(Ae,Be); go to MUL_O.
  - MUL_O: Po <= core(Ao,Bo); go to MUL_M.
  - MUL_M: Pm = core(Am,Bm), used combinationally, not stored. Register y from the recombination below; out_valid <= 1; go to DONE.
  - DONE:
    - out_valid=1; y held stable.
    - in_ready = out_ready.
    - out_ready=1 and in_valid=1: the new operands are captured, out_valid <= 0, next state MUL_E.
    - out_ready=1 and in_valid=0: out_valid <= 0, next state IDLE.
    - out_ready=0: stay in DONE; y and out_valid hold indefinitely.
- Recombination, all XOR, with T = Pm ^ Pe ^ Po:
  - y[2i] = Pe[i] ^ Po[i-1] for i=0..N-1. Pe[N-1] and Po[-1] are treated as 0, so y[0]=Pe[0] and y[2N-2]=Po[N-2].
  - y[2i+1] = T[i] for i=0..N-2.
- Timing and throughput:
  - Latency: operands accepted at edge k give out_valid=1 after edge k+3.
  - Continuous flow with out_ready=1 gives one result every 4 cycles.
- Operand capture: a/b are sampled only on the accepting edge. Later changes on a/b do not affect the in-flight product.
- No combinational path exists from in_valid to out_valid, or from a/b to y.
- In IDLE, y keeps the last delivered value (0 after reset); it is ignored while out_valid=0.

Test Plan:
- N=4: a=4'b1011, b=4'b0110, out_ready=1 -> out_valid after 3 edges; y=7'b0111010; in_ready low during MUL_E..MUL_M.
- N=82, edge values:
  - a=1, b=1 -> y=1.
  - a=1<<81, b=1<<81 -> y=1<<162 only.
  - a=all-ones, b=1 -> y[81:0]=all-ones, upper bits 0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> y and out_valid stable, in_ready=0, busy=1.
  - Raise out_ready with in_valid=0 -> IDLE next cycle.
- Back-to-back: two operand pairs offered continuously with out_ready=1 -> second out_valid exactly 4 cycles after the first, and both products correct.
- Reset mid-op: assert rst in MUL_O -> next cycle state IDLE, out_valid=0, y=0, in_ready=1. A subsequent op produces the correct result.
- Random: 10k random a/b for N=82 and N=8 -> y matches a software carry-less multiply; a/b toggled randomly after acceptance has no effect.
